design_10: RTL and testbench

//  Parametrised successor to the registered two-operand datapath: a W-bit, multi-op arithmetic unit

---
 rtl/design_10_pkg.sv | 15 +
 rtl/design_10_alu.sv | 47 ++++
 rtl/design_10.sv | 104 ++++++++++
 tb/tb_design_10.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/design_10_pkg.sv
// Shared definitions for the design_10 pipelined arithmetic unit.
package design_10_pkg;

    // Operation select carried with every operand beat.
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,  // wrapping add, ovf = carry-out
        OP_SUB  = 2'b01,  // wrapping subtract, ovf = borrow
        OP_ADDS = 2'b10,  // unsigned saturating add, ovf = saturated
        OP_ABSD = 2'b11   // absolute difference, ovf = 0
    } op_e;

    // Deepest pipeline the unit is meant to be built with.
    localparam int MAX_STAGES = 4;

endpackage

// File: rtl/design_10_alu.sv
// Combinational W-bit arithmetic core: {a, b, op} -> {y, ovf}.
module design_10_alu
    import design_10_pkg::*;
#(
    parameter int W = 20
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [1:0]   op_i,
    output logic [W-1:0] y_o,
    output logic         ovf_o
);

    logic [W:0] sum;
    logic [W:0] diff;

    // Shared W+1 bit adder/subtractor; the top bit is carry-out or borrow.
    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        diff  = {1'b0, a_i} - {1'b0, b_i};
        y_o   = sum[W-1:0];
        ovf_o = 1'b0;
        case (op_e'(op_i))
            OP_ADD: begin
                y_o   = sum[W-1:0];
                ovf_o = sum[W];
            end
            OP_SUB: begin
                y_o   = diff[W-1:0];
                ovf_o = diff[W];
            end
            OP_ADDS: begin
                y_o   = sum[W] ? {W{1'b1}} : sum[W-1:0];
                ovf_o = sum[W];
            end
            OP_ABSD: begin
                y_o   = diff[W] ? (b_i - a_i) : diff[W-1:0];
                ovf_o = 1'b0;
            end
            default: begin
                y_o   = sum[W-1:0];
                ovf_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/design_10.sv
// STAGES-deep pipelined arithmetic unit with valid/ready flow control on
// both sides.
//
// Handshake: a beat transfers on a rising clock edge exactly when valid and
// ready are both high in the cycle before it. The producer may change or
// withdraw an offered beat while in_ready is low. Once out_valid is high,
// out_valid, y and ovf stay frozen until out_ready takes the beat.
module design_10
    import design_10_pkg::*;
#(
    parameter int W      = 20,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         ovf,
    output logic         busy
);

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("design_10: STAGES must be in 1..MAX_STAGES");
    end

    logic [W-1:0]      alu_y;
    logic              alu_ovf;
    logic [STAGES-1:0] v_w;
    logic [STAGES-1:0] ovf_w;
    logic [W-1:0]      y_w [STAGES];
    logic [STAGES-1:0] load;
    logic              room;

    design_10_alu #(.W(W)) u_alu (
        .a_i   (a),
        .b_i   (b),
        .op_i  (op),
        .y_o   (alu_y),
        .ovf_o (alu_ovf)
    );

    // Ready chain: stage k may load when it, or any stage after it, is empty,
    // or when the consumer drains the last stage. This unrolls
    // load[k] = !v[k] | (v[k] & load[k+1]) without a self-referencing vector.
    always_comb begin
        load = '0;
        room = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            room    = room | ~v_w[k];
            load[k] = room;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         v_q;
        logic [W-1:0] y_q;
        logic         ovf_q;
        logic         v_d;
        logic [W-1:0] y_d;
        logic         ovf_d;

        if (k == 0) begin : g_head
            assign v_d   = in_valid;
            assign y_d   = alu_y;
            assign ovf_d = alu_ovf;
        end else begin : g_body
            assign v_d   = v_w[k-1];
            assign y_d   = y_w[k-1];
            assign ovf_d = ovf_w[k-1];
        end

        // Stage register: take the upstream beat (or bubble) whenever this stage can load.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                y_q   <= '0;
                ovf_q <= 1'b0;
            end else if (load[k]) begin
                v_q <= v_d;
                if (v_d) begin
                    y_q   <= y_d;
                    ovf_q <= ovf_d;
                end
            end
        end

        assign v_w[k]   = v_q;
        assign y_w[k]   = y_q;
        assign ovf_w[k] = ovf_q;
    end

    assign in_ready  = load[0];
    assign out_valid = v_w[STAGES-1];
    assign y         = y_w[STAGES-1];
    assign ovf       = ovf_w[STAGES-1];
    assign busy      = |v_w;

endmodule

// File: tb/tb_design_10.sv
// Bench for design_10: three instances (STAGES = 2, 1, 4) share one stimulus
// stream; each has its own expected-result queue and protocol monitor.
module tb_design_10;

    localparam int W    = 20;
    localparam int NDUT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   drv_exp;     // {ovf, y} expected for the beat on the inputs
    logic         exact_lat;   // latency must equal STAGES (out_ready steady high)

    logic         in_ready_w  [NDUT];
    logic         out_valid_w [NDUT];
    logic         ovf_w       [NDUT];
    logic         busy_w      [NDUT];
    logic [W-1:0] y_w         [NDUT];

    int cyc = 0;
    int n_pass = 0;
    int n_tot = 0;
    int q_size [NDUT];

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         ovf;
    } vec_t;

    vec_t tbl [10];

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model using wide integer arithmetic.
    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        longint lx = longint'(x);
        longint lz = longint'(z);
        longint top_v = (longint'(1) << W) - 1;
        logic [W:0] r;
        case (o)
            2'd0:    r = (lx + lz > top_v) ? {1'b1, W'(lx + lz - top_v - 1)} : {1'b0, W'(lx + lz)};
            2'd1:    r = (lx < lz) ? {1'b1, W'(lx - lz + top_v + 1)} : {1'b0, W'(lx - lz)};
            2'd2:    r = (lx + lz > top_v) ? {1'b1, W'(top_v)} : {1'b0, W'(lx + lz)};
            default: r = {1'b0, W'((lx < lz) ? (lz - lx) : (lx - lz))};
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] m = '1;
        if ($urandom_range(0, 3) == 0) return m - W'($urandom_range(0, 3));
        return W'($urandom);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        logic [W:0] exp_q [$];
        int         stamp_q [$];
        logic       hold;
        logic [W:0] hold_val;
        logic [W:0] e;
        int         lat;

        design_10 #(.W(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .op        (op),
            .a         (a),
            .b         (b),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .y         (y_w[g]),
            .ovf       (ovf_w[g]),
            .busy      (busy_w[g])
        );

        // Scoreboard and protocol monitor, sampled mid-cycle.
        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
                stamp_q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk($sformatf("hold_valid_s%0d", S), 64'(out_valid_w[g]), 64'(1));
                    chk($sformatf("hold_data_s%0d", S), 64'({ovf_w[g], y_w[g]}), 64'(hold_val));
                end
                if (out_valid_w[g] && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("spurious_out_s%0d", S), 64'(out_valid_w[g]), 64'(0));
                    end else begin
                        e   = exp_q.pop_front();
                        lat = cyc - stamp_q.pop_front();
                        chk($sformatf("result_s%0d", S), 64'({ovf_w[g], y_w[g]}), 64'(e));
                        if (exact_lat) chk($sformatf("latency_s%0d", S), 64'(lat), 64'(S));
                        else           chk($sformatf("latency_min_s%0d", S), 64'(lat >= S), 64'(1));
                    end
                end
                if (in_valid && in_ready_w[g]) begin
                    exp_q.push_back(drv_exp);
                    stamp_q.push_back(cyc);
                end
                hold     = out_valid_w[g] && !out_ready;
                hold_val = {ovf_w[g], y_w[g]};
            end
            q_size[g] = exp_q.size();
        end
    end

    // Offer one beat to the STAGES=2 instance and wait (bounded) for its acceptance.
    task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z, input logic [W:0] e);
        int n = 0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = z;
        drv_exp  = e;
        @(negedge clk);
        while (!in_ready_w[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_w[0]) chk("send_timeout", 64'(in_ready_w[0]), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_tot + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b00, 20'hFFFFF, 20'h00001, 20'h00000, 1'b1};
        tbl[1] = '{2'b01, 20'h00005, 20'h00007, 20'hFFFFE, 1'b1};
        tbl[2] = '{2'b10, 20'hFFFF0, 20'h00020, 20'hFFFFF, 1'b1};
        tbl[3] = '{2'b11, 20'h00003, 20'h00010, 20'h0000D, 1'b0};
        tbl[4] = '{2'b00, 20'h12345, 20'h11111, 20'h23456, 1'b0};
        tbl[5] = '{2'b01, 20'h00007, 20'h00005, 20'h00002, 1'b0};
        tbl[6] = '{2'b10, 20'hFFFF0, 20'h0000F, 20'hFFFFF, 1'b0};
        tbl[7] = '{2'b11, 20'h00010, 20'h00003, 20'h0000D, 1'b0};
        tbl[8] = '{2'b01, 20'h00009, 20'h00009, 20'h00000, 1'b0};
        tbl[9] = '{2'b11, 20'hFFFFF, 20'h00000, 20'hFFFFF, 1'b0};

        // reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 2'b00;
        a         = '0;
        b         = '0;
        drv_exp   = '0;
        exact_lat = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid_w[0]), 64'(0));
        chk("reset_y", 64'(y_w[0]), 64'(0));
        chk("reset_ovf", 64'(ovf_w[0]), 64'(0));
        chk("reset_busy", 64'(busy_w[0]), 64'(0));
        chk("reset_in_ready", 64'(in_ready_w[0]), 64'(1));
        @(posedge clk);
        #1;

        // directed operation table, back to back, exact latency
        for (int i = 0; i < 10; i++)
            send(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].ovf, tbl[i].y});
        idle(6);
        chk("table_drained", 64'(q_size[0]), 64'(0));

        // streaming ADD a=i, b=i
        for (int i = 0; i < 16; i++)
            send(2'b00, W'(i), W'(i), {1'b0, W'(2 * i)});
        idle(6);
        chk("stream_drained", 64'(q_size[0]), 64'(0));

        // backpressure: fill, stall 5 cycles with a changing beat offered
        exact_lat = 1'b0;
        out_ready = 1'b0;
        send(2'b00, 20'h00064, 20'h00001, {1'b0, 20'h00065});
        send(2'b10, 20'hFFFFE, 20'h00005, {1'b1, 20'hFFFFF});
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op       = 2'b01;
            a        = W'($urandom);
            b        = W'($urandom);
            drv_exp  = model(op, a, b);
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready_w[0]), 64'(0));
            chk("bp_out_valid", 64'(out_valid_w[0]), 64'(1));
            chk("bp_busy", 64'(busy_w[0]), 64'(1));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(2'b11, 20'h00100, 20'h00200, {1'b0, 20'h00100});
        idle(8);
        chk("bp_drained", 64'(q_size[0]), 64'(0));

        // reset with two beats in flight
        out_ready = 1'b0;
        send(2'b00, 20'h00001, 20'h00002, {1'b0, 20'h00003});
        send(2'b00, 20'h00004, 20'h00005, {1'b0, 20'h00009});
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid_w[0]), 64'(0));
        chk("midrst_y", 64'(y_w[0]), 64'(0));
        chk("midrst_ovf", 64'(ovf_w[0]), 64'(0));
        chk("midrst_busy", 64'(busy_w[0]), 64'(0));
        chk("midrst_busy_s4", 64'(busy_w[2]), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        exact_lat = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 64'(in_ready_w[0]), 64'(1));
        chk("postrst_out_valid", 64'(out_valid_w[0]), 64'(0));
        @(posedge clk);
        #1;
        send(2'b00, 20'h00001, 20'h00001, {1'b0, 20'h00002});
        idle(6);
        chk("postrst_drained", 64'(q_size[0]), 64'(0));

        // random traffic on all three instances
        exact_lat = 1'b0;
        for (int i = 0; i < 25000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            op        = 2'($urandom_range(0, 3));
            a         = rnd_operand();
            b         = rnd_operand();
            drv_exp   = model(op, a, b);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(10);
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("rand_drained_%0d", g), 64'(q_size[g]), 64'(0));
            chk($sformatf("rand_idle_busy_%0d", g), 64'(busy_w[g]), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
